// File: rtl/ram_dp_be_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_be_if
// Description : Bus bundle for the dual-port byte-enable RAM. It carries both
//               access ports plus the conflict outputs. The master modport is
//               the requester side and the slave modport is the memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_dp_be_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) ();
    localparam int NUM_BYTES = WIDTH / 8;

    // Port A
    logic                  a_en;
    logic [NUM_BYTES-1:0]  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [WIDTH-1:0]      a_wdata;
    logic [WIDTH-1:0]      a_rdata;
    logic                  a_rvalid;

    // Port B
    logic                  b_en;
    logic [NUM_BYTES-1:0]  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [WIDTH-1:0]      b_wdata;
    logic [WIDTH-1:0]      b_rdata;
    logic                  b_rvalid;

    // Conflict reporting
    logic                  collision;
    logic [15:0]           collision_cnt;

    modport master (
        output a_en, a_we, a_addr, a_wdata,
        input  a_rdata, a_rvalid,
        output b_en, b_we, b_addr, b_wdata,
        input  b_rdata, b_rvalid,
        input  collision, collision_cnt
    );

    modport slave (
        input  a_en, a_we, a_addr, a_wdata,
        output a_rdata, a_rvalid,
        input  b_en, b_we, b_addr, b_wdata,
        output b_rdata, b_rvalid,
        output collision, collision_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_be
// Description : True dual-port synchronous RAM with per-byte write enables,
//               selectable read-during-write behaviour (READ_FIRST,
//               WRITE_FIRST, NO_CHANGE) and a 1- or 2-cycle read pipeline.
//               Same-address cross-port conflicts resolve deterministically:
//               port A wins overlapping byte lanes, a reading port always
//               sees the pre-write word. A one-cycle collision pulse is
//               produced for every conflict.
//               Optional feature macro: RAM_DP_BE_COLLISION_CNT_EN enables
//               the 16-bit saturating conflict counter; without it the
//               collision_cnt output is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dp_be #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0
) (
    input wire         clk,
    input wire         rst_n,
    ram_dp_be_if.slave bus
);
    localparam int NUM_BYTES        = WIDTH / 8;
    localparam int DEPTH            = 2 ** ADDR_WIDTH;
    localparam int MODE_READ_FIRST  = 0;
    localparam int MODE_WRITE_FIRST = 1;
    localparam int MODE_NO_CHANGE   = 2;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Storage starts out all-zero; reset never touches it.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             a_is_wr;
    logic             b_is_wr;
    logic             same_addr;
    logic             a_wr_req;
    logic             b_wr_req;
    logic             a_wr_acc;
    logic             b_wr_acc;
    logic             conflict;
    logic [WIDTH-1:0] a_old;
    logic [WIDTH-1:0] b_old;
    logic [WIDTH-1:0] a_final;
    logic [WIDTH-1:0] b_final;

    assign a_is_wr   = |bus.a_we;
    assign b_is_wr   = |bus.b_we;
    assign same_addr = (bus.a_addr == bus.b_addr);
    assign a_wr_req  = bus.a_en && a_is_wr;
    assign b_wr_req  = bus.b_en && b_is_wr;

    // Writes are qualified with the reset level so that edges seen while
    // reset is held leave the array untouched.
    assign a_wr_acc  = a_wr_req && rst_n;
    assign b_wr_acc  = b_wr_req && rst_n;

    // Two reads of one address are harmless; only a write makes it a conflict.
    assign conflict  = bus.a_en && bus.b_en && same_addr && (a_is_wr || b_is_wr);

    // Pre-write words, also what a reading port returns under conflict.
    assign a_old     = mem[bus.a_addr];
    assign b_old     = mem[bus.b_addr];

    // Final stored word at each port's address after the A-priority merge.
    // When the addresses match both results are identical, so the two
    // array writes below can never disagree.
    always_comb begin
        a_final = a_old;
        b_final = b_old;
        for (int lane = 0; lane < NUM_BYTES; lane++) begin
            if (same_addr && b_wr_req && bus.b_we[lane]) begin
                a_final[8*lane +: 8] = bus.b_wdata[8*lane +: 8];
            end
            if (bus.a_we[lane]) begin
                a_final[8*lane +: 8] = bus.a_wdata[8*lane +: 8];
            end
            if (bus.b_we[lane]) begin
                b_final[8*lane +: 8] = bus.b_wdata[8*lane +: 8];
            end
            if (same_addr && a_wr_req && bus.a_we[lane]) begin
                b_final[8*lane +: 8] = bus.a_wdata[8*lane +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Array write: whole merged words, B first then A
    // ------------------------------------------------------------------
    // Commit merged words for every accepted write.
    always_ff @(posedge clk) begin
        if (b_wr_acc) begin
            mem[bus.b_addr] <= b_final;
        end
        if (a_wr_acc) begin
            mem[bus.a_addr] <= a_final;
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1
    // ------------------------------------------------------------------
    logic             a_s1_load;
    logic             b_s1_load;
    logic [WIDTH-1:0] a_s1_next;
    logic [WIDTH-1:0] b_s1_next;
    logic             a_s1_valid;
    logic             b_s1_valid;
    logic [WIDTH-1:0] a_s1_data;
    logic [WIDTH-1:0] b_s1_data;

    // A write in NO_CHANGE mode produces nothing; every other access does.
    assign a_s1_load = bus.a_en && (!a_is_wr || (WRITE_MODE != MODE_NO_CHANGE));
    assign b_s1_load = bus.b_en && (!b_is_wr || (WRITE_MODE != MODE_NO_CHANGE));

    // Only a write in WRITE_FIRST mode reports the merged word.
    assign a_s1_next = (a_is_wr && (WRITE_MODE == MODE_WRITE_FIRST)) ? a_final : a_old;
    assign b_s1_next = (b_is_wr && (WRITE_MODE == MODE_WRITE_FIRST)) ? b_final : b_old;

    // Port A first read stage; data holds when nothing is returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_valid <= 1'b0;
            a_s1_data  <= '0;
        end else begin
            a_s1_valid <= a_s1_load;
            if (a_s1_load) begin
                a_s1_data <= a_s1_next;
            end
        end
    end

    // Port B first read stage; data holds when nothing is returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_s1_valid <= 1'b0;
            b_s1_data  <= '0;
        end else begin
            b_s1_valid <= b_s1_load;
            if (b_s1_load) begin
                b_s1_data <= b_s1_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional read stage 2
    // ------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_rl2
        logic             a_s2_valid;
        logic             b_s2_valid;
        logic [WIDTH-1:0] a_s2_data;
        logic [WIDTH-1:0] b_s2_data;

        // Second stage copies stage 1 only when stage 1 holds a response.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_s2_valid <= 1'b0;
                a_s2_data  <= '0;
                b_s2_valid <= 1'b0;
                b_s2_data  <= '0;
            end else begin
                a_s2_valid <= a_s1_valid;
                b_s2_valid <= b_s1_valid;
                if (a_s1_valid) begin
                    a_s2_data <= a_s1_data;
                end
                if (b_s1_valid) begin
                    b_s2_data <= b_s1_data;
                end
            end
        end

        assign bus.a_rdata  = a_s2_data;
        assign bus.a_rvalid = a_s2_valid;
        assign bus.b_rdata  = b_s2_data;
        assign bus.b_rvalid = b_s2_valid;
    end else begin : g_rl1
        assign bus.a_rdata  = a_s1_data;
        assign bus.a_rvalid = a_s1_valid;
        assign bus.b_rdata  = b_s1_data;
        assign bus.b_rvalid = b_s1_valid;
    end

    // ------------------------------------------------------------------
    // Conflict reporting
    // ------------------------------------------------------------------
    logic collision_q;

    // Collision pulse follows the conflicting edge by one cycle regardless
    // of the read pipeline depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= conflict;
        end
    end

    assign bus.collision = collision_q;

`ifdef RAM_DP_BE_COLLISION_CNT_EN
    logic [15:0] coll_cnt;

    // Saturating count of conflicts, updated on the same edge as the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt <= '0;
        end else if (conflict && (coll_cnt != CNT_MAX)) begin
            coll_cnt <= coll_cnt + 16'd1;
        end
    end

    assign bus.collision_cnt = coll_cnt;
`else
    assign bus.collision_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_dp_be
// Description : Scoreboard bench for ram_dp_be. Four instances share one
//               stimulus stream: WRITE_MODE 0/1/2 at READ_LATENCY 1, and
//               WRITE_MODE 0 at READ_LATENCY 2. Expected responses are
//               queued at issue time and retired by per-instance monitors.
//               Honours RAM_DP_BE_COLLISION_CNT_EN for counter expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dp_be;
    localparam int NI = 4;
    localparam int W  = 32;
    localparam int AW = 8;
`ifdef RAM_DP_BE_COLLISION_CNT_EN
    localparam int NCONF   = 65540;
    localparam int CNT_END = 16'hFFFF;
`else
    localparam int NCONF   = 4;
    localparam int CNT_END = 0;
`endif

    typedef struct packed {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int exp_cnt     = 0;

    exp_t        qa [NI][$];
    exp_t        qb [NI][$];
    exp_t        qc [NI][$];
    logic [31:0] mdl [256];

    // shared stimulus
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [3:0]  a_we = '0,   b_we = '0;
    logic [7:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;

    // observed outputs
    logic [31:0] a_rd_w [NI];
    logic [31:0] b_rd_w [NI];
    logic        a_rv_w [NI];
    logic        b_rv_w [NI];
    logic        coll_w [NI];
    logic [15:0] cnt_w  [NI];

    function automatic int lat(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int mode(input int i);
        return (i == 3) ? 0 : i;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)", name, inst, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        ram_dp_be_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

        assign bus.a_en    = a_en;
        assign bus.a_we    = a_we;
        assign bus.a_addr  = a_addr;
        assign bus.a_wdata = a_wdata;
        assign bus.b_en    = b_en;
        assign bus.b_we    = b_we;
        assign bus.b_addr  = b_addr;
        assign bus.b_wdata = b_wdata;

        assign a_rd_w[gi] = bus.a_rdata;
        assign b_rd_w[gi] = bus.b_rdata;
        assign a_rv_w[gi] = bus.a_rvalid;
        assign b_rv_w[gi] = bus.b_rvalid;
        assign coll_w[gi] = bus.collision;
        assign cnt_w[gi]  = bus.collision_cnt;

        ram_dp_be #(
            .WIDTH        (W),
            .ADDR_WIDTH   (AW),
            .READ_LATENCY ((gi == 3) ? 2 : 1),
            .WRITE_MODE   ((gi == 3) ? 0 : gi)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Monitor: retire expected responses as outputs appear.
        always @(negedge clk) begin : mon
            exp_t e;
            while (qa[gi].size() > 0 && qa[gi][0].due < cyc) begin
                e = qa[gi].pop_front();
                chk("a_rvalid_missing", gi, 32'd0, 32'd1);
            end
            if (bus.a_rvalid) begin
                if (qa[gi].size() == 0) chk("a_rvalid_unexpected", gi, 32'd1, 32'd0);
                else begin
                    e = qa[gi].pop_front();
                    chk("a_rdata", gi, bus.a_rdata, e.data);
                    chk("a_latency", gi, cyc, e.due);
                end
            end
            while (qb[gi].size() > 0 && qb[gi][0].due < cyc) begin
                e = qb[gi].pop_front();
                chk("b_rvalid_missing", gi, 32'd0, 32'd1);
            end
            if (bus.b_rvalid) begin
                if (qb[gi].size() == 0) chk("b_rvalid_unexpected", gi, 32'd1, 32'd0);
                else begin
                    e = qb[gi].pop_front();
                    chk("b_rdata", gi, bus.b_rdata, e.data);
                    chk("b_latency", gi, cyc, e.due);
                end
            end
            while (qc[gi].size() > 0 && qc[gi][0].due < cyc) begin
                e = qc[gi].pop_front();
                chk("collision_missing", gi, 32'd0, 32'd1);
            end
            if (bus.collision) begin
                if (qc[gi].size() == 0) chk("collision_unexpected", gi, 32'd1, 32'd0);
                else begin
                    e = qc[gi].pop_front();
                    chk("collision_time", gi, cyc, e.due);
                    chk("collision_cnt", gi, {16'h0, bus.collision_cnt}, e.data);
                end
            end
        end
    end

    // One clock of stimulus on both ports; the model and queues are updated
    // only when the edge will actually be accepted.
    task automatic beat(input bit ae, input logic [3:0] awe, input logic [7:0] aad,
                        input logic [31:0] awd, input logic [31:0] aexp,
                        input bit be, input logic [3:0] bwe, input logic [7:0] bad,
                        input logic [31:0] bwd, input logic [31:0] bexp);
        logic [31:0] old_a, old_b, fin_a, fin_b;
        bit          aw, bw;
        exp_t        e;
        a_en = ae; a_we = awe; a_addr = aad; a_wdata = awd;
        b_en = be; b_we = bwe; b_addr = bad; b_wdata = bwd;
        if (rst_n) begin
            aw    = ae && (awe != 4'b0);
            bw    = be && (bwe != 4'b0);
            old_a = mdl[aad];
            old_b = mdl[bad];
            // apply B then A so A owns any overlapping lane
            for (int l = 0; l < 4; l++) begin
                if (bw && bwe[l]) mdl[bad][8*l +: 8] = bwd[8*l +: 8];
            end
            for (int l = 0; l < 4; l++) begin
                if (aw && awe[l]) mdl[aad][8*l +: 8] = awd[8*l +: 8];
            end
            fin_a = mdl[aad];
            fin_b = mdl[bad];
            if (ae && be && (aad == bad) && (aw || bw)) begin
`ifdef RAM_DP_BE_COLLISION_CNT_EN
                if (exp_cnt != 16'hFFFF) exp_cnt++;
`endif
                for (int i = 0; i < NI; i++) begin
                    e.data = exp_cnt; e.due = cyc + 1; qc[i].push_back(e);
                end
            end
            for (int i = 0; i < NI; i++) begin
                e.due = cyc + lat(i);
                if (ae) begin
                    if (!aw)              begin e.data = aexp;  qa[i].push_back(e); end
                    else if (mode(i) == 0) begin e.data = old_a; qa[i].push_back(e); end
                    else if (mode(i) == 1) begin e.data = fin_a; qa[i].push_back(e); end
                end
                if (be) begin
                    if (!bw)              begin e.data = bexp;  qb[i].push_back(e); end
                    else if (mode(i) == 0) begin e.data = old_b; qb[i].push_back(e); end
                    else if (mode(i) == 1) begin e.data = fin_b; qb[i].push_back(e); end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(0, 4'h0, 8'h0, 32'h0, 32'h0, 0, 4'h0, 8'h0, 32'h0, 32'h0);
    endtask

    task automatic wr_a(input logic [7:0] ad, input logic [3:0] we, input logic [31:0] d);
        beat(1, we, ad, d, 32'h0, 0, 4'h0, 8'h0, 32'h0, 32'h0);
    endtask

    task automatic rd_a(input logic [7:0] ad, input logic [31:0] exp);
        beat(1, 4'h0, ad, 32'h0, exp, 0, 4'h0, 8'h0, 32'h0, 32'h0);
    endtask

    task automatic rd_b(input logic [7:0] ad, input logic [31:0] exp);
        beat(0, 4'h0, 8'h0, 32'h0, 32'h0, 1, 4'h0, ad, 32'h0, exp);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin : stim
        for (int k = 0; k < 256; k++) mdl[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("reset_a_rdata", i, a_rd_w[i], 32'h0);
            chk("reset_a_rvalid", i, {31'h0, a_rv_w[i]}, 32'h0);
            chk("reset_b_rdata", i, b_rd_w[i], 32'h0);
            chk("reset_b_rvalid", i, {31'h0, b_rv_w[i]}, 32'h0);
            chk("reset_collision", i, {31'h0, coll_w[i]}, 32'h0);
            chk("reset_cnt", i, {16'h0, cnt_w[i]}, 32'h0);
        end
        rst_n = 1'b1;

        // byte-enable merge, then back-to-back read on the same port
        wr_a(8'd5, 4'b1111, 32'h11223344);
        wr_a(8'd5, 4'b0101, 32'hAABBCCDD);
        rd_a(8'd5, 32'h11BB33DD);

        // write-mode sweep at addr 3
        wr_a(8'd3, 4'b1111, 32'hDEADBEEF);
        rd_a(8'd3, 32'hDEADBEEF);
        wr_a(8'd3, 4'b1111, 32'h00000000);
        chk("nochange_rdata_hold", 2, a_rd_w[2], 32'hDEADBEEF);
        chk("nochange_rvalid", 2, {31'h0, a_rv_w[2]}, 32'h0);
        rd_a(8'd3, 32'h00000000);

        // dual write conflict at addr 9, then two reads of the same word
        beat(1, 4'b0011, 8'd9, 32'hAAAAAAAA, 32'h0, 1, 4'b0110, 8'd9, 32'hBBBBBBBB, 32'h0);
        beat(1, 4'b0000, 8'd9, 32'h0, 32'h00BBAAAA, 1, 4'b0000, 8'd9, 32'h0, 32'h00BBAAAA);

        // read/write conflict at addr 7
        wr_a(8'd7, 4'b1111, 32'h12345678);
        beat(1, 4'b1111, 8'd7, 32'hFFFFFFFF, 32'h0, 1, 4'b0000, 8'd7, 32'h0, 32'h12345678);
        rd_b(8'd7, 32'hFFFFFFFF);
        idle(3);

        // reset in the middle of a read burst
        rd_a(8'd5, 32'h11BB33DD);
        rd_a(8'd3, 32'h00000000);
        rst_n = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < NI; i++) begin
            qa[i].delete(); qb[i].delete(); qc[i].delete();
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("async_reset_a_rvalid", i, {31'h0, a_rv_w[i]}, 32'h0);
            chk("async_reset_a_rdata", i, a_rd_w[i], 32'h0);
            chk("async_reset_cnt", i, {16'h0, cnt_w[i]}, 32'h0);
        end
        rd_a(8'd9, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        rd_a(8'd5, 32'h11BB33DD);
        idle(3);

        // repeated read/write conflicts on addr 0 (counter run)
        for (int n = 0; n < NCONF; n++) begin
            logic [31:0] prev;
            prev = (n == 0) ? 32'h0 : {24'h0, 8'(n - 1)};
            beat(1, 4'b0001, 8'd0, {24'h0, 8'(n)}, 32'h0, 1, 4'b0000, 8'd0, 32'h0, prev);
        end
        idle(4);
        for (int i = 0; i < NI; i++) begin
            chk("cnt_final", i, {16'h0, cnt_w[i]}, CNT_END);
            chk("a_queue_drained", i, qa[i].size(), 32'd0);
            chk("b_queue_drained", i, qb[i].size(), 32'd0);
            chk("collision_queue_drained", i, qc[i].size(), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
